// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg
// Shared definitions for the program-counter unit: the two-state FSM type,
// the decoded action the next-PC mux hands back to the register stage, the
// exc_cause encodings and the default reset/exception vectors.
// Ports: none (package).
// Configuration: PC_ALIGN_TRAP_EN (see pc_next / pc_unit) selects whether a
// misaligned redirect in RUN traps or is silently aligned.
package pc_unit_pkg;

   // FSM states: normal execution and inside the exception handler
   typedef enum logic {
      RUN     = 1'b0,
      HANDLER = 1'b1
   } pc_state_t;

   // What the next-PC mux decided to do this cycle
   typedef enum logic [2:0] {
      ACT_INC   = 3'd0,
      ACT_REDIR = 3'd1,
      ACT_EXC   = 3'd2,
      ACT_TRAP  = 3'd3,
      ACT_ERET  = 3'd4
   } pc_action_t;

   // exc_cause encodings
   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_EXT      = 2'd1;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

   // Default vectors and sequential step
   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0040_0000;
   localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h8000_0180;
   localparam int unsigned DEFAULT_INC       = 4;

endpackage

// File: rtl/pc_next.sv
// pc_next
// Combinational next-PC and priority selection for pc_unit.
// Priority: exception (RUN only) > eret (HANDLER only) > redirect > increment.
// Configuration: with PC_ALIGN_TRAP_EN defined, a misaligned redirect taken
// in RUN becomes a trap to excVec; otherwise (and always in HANDLER) the
// redirect target has its two low bits cleared.
// Ports:
//   state      - current FSM state
//   pc, epc    - current PC and saved exception PC
//   redir_valid, redir_pc - redirect request and target
//   exc_req, eret_req     - exception / return-from-exception requests
//   action     - decoded action for the register stage
//   nextPc     - PC to load if the unit is enabled
module pc_next
   import pc_unit_pkg::*;
#(
   parameter int unsigned       WIDTH   = 32,
   parameter logic [WIDTH-1:0]  EXC_VEC = WIDTH'(DEFAULT_EXC_VEC),
   parameter int unsigned       INC     = DEFAULT_INC
) (
   input  pc_state_t         state,
   input  logic [WIDTH-1:0]  pc,
   input  logic [WIDTH-1:0]  epc,
   input  logic              redir_valid,
   input  logic [WIDTH-1:0]  redir_pc,
   input  logic              exc_req,
   input  logic              eret_req,
   output pc_action_t        action,
   output logic [WIDTH-1:0]  nextPc
);

   logic [WIDTH-1:0] alignedTarget;

   // Redirect target with the low two bits forced to zero; used whenever a
   // redirect is taken without trapping.
   always_comb begin
      alignedTarget = redir_pc & ~WIDTH'(3);
   end

   // Priority mux. Requests that are meaningless in the current state
   // (exception while already in the handler, eret outside it) simply fall
   // through so the lower-priority requests get evaluated instead.
   always_comb begin
      action = ACT_INC;
      nextPc = pc + WIDTH'(INC);
      if (exc_req && (state == RUN)) begin
         action = ACT_EXC;
         nextPc = EXC_VEC;
      end else if (eret_req && (state == HANDLER)) begin
         action = ACT_ERET;
         nextPc = epc;
      end else if (redir_valid) begin
`ifdef PC_ALIGN_TRAP_EN
         if ((state == RUN) && (redir_pc[1:0] != 2'b00)) begin
            action = ACT_TRAP;
            nextPc = EXC_VEC;
         end else begin
            action = ACT_REDIR;
            nextPc = alignedTarget;
         end
`else
         action = ACT_REDIR;
         nextPc = alignedTarget;
`endif
      end
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit
// Program-counter unit with a RUN/HANDLER exception FSM, saved EPC and
// last-cause register. All state advances only when ena=1; rst (synchronous,
// active-low) overrides everything and returns the unit to RUN.
// Configuration macro: PC_ALIGN_TRAP_EN - misaligned redirect in RUN traps
// with cause 2 instead of being aligned.
// Ports:
//   clk, rst     - clock and synchronous active-low reset
//   ena          - advance enable (0 = stall)
//   redir_valid, redir_pc - branch/jump redirect
//   exc_req, eret_req     - exception entry / return
//   pc_out, epc_out       - current PC and saved exception PC
//   exc_cause    - 0 none, 1 external, 2 misaligned target
//   in_handler   - high while in HANDLER
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
   parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(DEFAULT_EXC_VEC),
   parameter int unsigned       INC       = DEFAULT_INC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              redir_valid,
   input  logic [WIDTH-1:0]  redir_pc,
   input  logic              exc_req,
   input  logic              eret_req,
   output logic [WIDTH-1:0]  pc_out,
   output logic [WIDTH-1:0]  epc_out,
   output logic [1:0]        exc_cause,
   output logic              in_handler
);

   pc_state_t        state;
   pc_state_t        nextState;
   pc_action_t       action;
   logic [WIDTH-1:0] nextPc;
   logic [WIDTH-1:0] nextEpc;
   logic [1:0]       nextCause;

   pc_next #(
      .WIDTH   (WIDTH),
      .EXC_VEC (EXC_VEC),
      .INC     (INC)
   ) u_pc_next (
      .state       (state),
      .pc          (pc_out),
      .epc         (epc_out),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .exc_req     (exc_req),
      .eret_req    (eret_req),
      .action      (action),
      .nextPc      (nextPc)
   );

   // Next-state logic: the mux already decided which request wins, so here
   // we only translate that action into FSM, EPC and cause updates. EPC is
   // touched only on an accepted exception or trap; redirects and plain
   // increments leave cause alone.
   always_comb begin
      nextState = state;
      nextEpc   = epc_out;
      nextCause = exc_cause;
      case (action)
         ACT_EXC: begin
            nextState = HANDLER;
            nextEpc   = pc_out;
            nextCause = CAUSE_EXT;
         end
         ACT_TRAP: begin
            nextState = HANDLER;
            nextEpc   = redir_pc;
            nextCause = CAUSE_MISALIGN;
         end
         ACT_ERET: begin
            nextState = RUN;
            nextCause = CAUSE_NONE;
         end
         default: begin
            nextState = state;
         end
      endcase
   end

   // State and output registers. Reset wins over ena and every request; with
   // ena low everything holds, even if requests are pending.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         pc_out    <= RESET_VEC;
         epc_out   <= '0;
         exc_cause <= CAUSE_NONE;
      end else if (ena) begin
         state     <= nextState;
         pc_out    <= nextPc;
         epc_out   <= nextEpc;
         exc_cause <= nextCause;
      end
   end

   // Handler flag straight from the state register
   always_comb begin
      in_handler = (state == HANDLER);
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
// Self-checking bench for pc_unit: a directed vector table, a randomized
// run against a behavioural model, and an 8-bit instance for wrap-around
// and reset-in-handler behaviour. Honors PC_ALIGN_TRAP_EN.
module tb_pc_unit;

`ifdef PC_ALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   localparam logic [31:0] RVEC = 32'h0040_0000;
   localparam logic [31:0] EVEC = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst, ena, redir_valid, exc_req, eret_req;
   logic [31:0] redir_pc;
   logic [31:0] pc_out, epc_out;
   logic [1:0]  exc_cause;
   logic        in_handler;

   logic        rst8, ena8, redirValid8, excReq8, eretReq8;
   logic [7:0]  redirPc8;
   logic [7:0]  pcOut8, epcOut8;
   logic [1:0]  excCause8;
   logic        inHandler8;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] mPc, mEpc;
   logic [1:0]  mCause;
   logic        mHandler;

   typedef struct {
      string       name;
      logic        rstN, en, exc, eret, rv;
      logic [31:0] target;
      logic [31:0] expPc, expEpc;
      logic [1:0]  expCause;
      logic        expHandler;
   } vec_t;

   vec_t vecs[$];

   // Free-running clock
   always #5 clk = ~clk;

   pc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .exc_req     (exc_req),
      .eret_req    (eret_req),
      .pc_out      (pc_out),
      .epc_out     (epc_out),
      .exc_cause   (exc_cause),
      .in_handler  (in_handler)
   );

   pc_unit #(
      .WIDTH     (8),
      .RESET_VEC (8'hFC)
   ) dut8 (
      .clk         (clk),
      .rst         (rst8),
      .ena         (ena8),
      .redir_valid (redirValid8),
      .redir_pc    (redirPc8),
      .exc_req     (excReq8),
      .eret_req    (eretReq8),
      .pc_out      (pcOut8),
      .epc_out     (epcOut8),
      .exc_cause   (excCause8),
      .in_handler  (inHandler8)
   );

   // Behavioural model: one accepted edge of the PC unit, described directly
   // from the priority rules with plain arithmetic.
   task automatic stepModel(input logic r, input logic e, input logic x,
                            input logic er, input logic rv, input logic [31:0] t);
      logic [31:0] offset;
      offset = t % 4;
      if (!r) begin
         mPc = RVEC; mEpc = 32'h0; mCause = 2'd0; mHandler = 1'b0;
      end else if (e) begin
         if (x && !mHandler) begin
            mEpc = mPc; mPc = EVEC; mCause = 2'd1; mHandler = 1'b1;
         end else if (er && mHandler) begin
            mPc = mEpc; mCause = 2'd0; mHandler = 1'b0;
         end else if (rv && TRAP_ON && (offset != 0) && !mHandler) begin
            mEpc = t; mPc = EVEC; mCause = 2'd2; mHandler = 1'b1;
         end else if (rv) begin
            mPc = t - offset;
         end else begin
            mPc = mPc + 32'd4;
         end
      end
   endtask

   // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit
   // later and advance the model to match.
   task automatic applyStimulus(input logic r, input logic e, input logic x,
                                input logic er, input logic rv, input logic [31:0] t);
      rst = r; ena = e; exc_req = x; eret_req = er; redir_valid = rv; redir_pc = t;
      @(posedge clk);
      #1;
      stepModel(r, e, x, er, rv, t);
   endtask

   // Single comparison with failure report
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic addVec(input string n, input logic r, input logic e, input logic x,
                         input logic er, input logic rv, input logic [31:0] t,
                         input logic [31:0] p, input logic [31:0] ep,
                         input logic [1:0] c, input logic h);
      vec_t v;
      v.name = n; v.rstN = r; v.en = e; v.exc = x; v.eret = er; v.rv = rv;
      v.target = t; v.expPc = p; v.expEpc = ep; v.expCause = c; v.expHandler = h;
      vecs.push_back(v);
   endtask

   task automatic step8(input logic r, input logic e, input logic x);
      rst8 = r; ena8 = e; excReq8 = x;
      @(posedge clk);
      #1;
   endtask

   // Main test sequence
   initial begin
      rst = 1'b0; ena = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
      redir_valid = 1'b0; redir_pc = 32'h0;
      rst8 = 1'b0; ena8 = 1'b0; redirValid8 = 1'b0; redirPc8 = 8'h0;
      excReq8 = 1'b0; eretReq8 = 1'b0;
      mPc = RVEC; mEpc = 32'h0; mCause = 2'd0; mHandler = 1'b0;

      //      name                 r  e  x  er rv target        pc            epc           c  h
      addVec("reset",              0, 0, 0, 0, 0, 32'h0,        32'h00400000, 32'h0,        0, 0);
      addVec("inc1",               1, 1, 0, 0, 0, 32'h0,        32'h00400004, 32'h0,        0, 0);
      addVec("inc2",               1, 1, 0, 0, 0, 32'h0,        32'h00400008, 32'h0,        0, 0);
      addVec("inc3",               1, 1, 0, 0, 0, 32'h0,        32'h0040000C, 32'h0,        0, 0);
      addVec("stallRedir",         1, 0, 0, 0, 1, 32'h00401000, 32'h0040000C, 32'h0,        0, 0);
      addVec("redir",              1, 1, 0, 0, 1, 32'h00401000, 32'h00401000, 32'h0,        0, 0);
      addVec("redirTo10",          1, 1, 0, 0, 1, 32'h00400010, 32'h00400010, 32'h0,        0, 0);
      addVec("excBeatsRedir",      1, 1, 1, 0, 1, 32'h00401000, 32'h80000180, 32'h00400010, 1, 1);
      addVec("nestedExcIgnored",   1, 1, 1, 0, 0, 32'h0,        32'h80000184, 32'h00400010, 1, 1);
      addVec("eret",               1, 1, 0, 1, 0, 32'h0,        32'h00400010, 32'h00400010, 0, 0);
      addVec("eretInRunIgnored",   1, 1, 0, 1, 0, 32'h0,        32'h00400014, 32'h00400010, 0, 0);
`ifdef PC_ALIGN_TRAP_EN
      addVec("misalignedRedir",    1, 1, 0, 0, 1, 32'h00400102, 32'h80000180, 32'h00400102, 2, 1);
      addVec("eretAfterTrap",      1, 1, 0, 1, 0, 32'h0,        32'h00400102, 32'h00400102, 0, 0);
`else
      addVec("misalignedRedir",    1, 1, 0, 0, 1, 32'h00400102, 32'h00400100, 32'h00400010, 0, 0);
      addVec("eretAfterRedir",     1, 1, 0, 1, 0, 32'h0,        32'h00400104, 32'h00400010, 0, 0);
`endif
      addVec("resetOverrides",     0, 1, 1, 0, 0, 32'h0,        32'h00400000, 32'h0,        0, 0);
      addVec("exc",                1, 1, 1, 0, 0, 32'h0,        32'h80000180, 32'h00400000, 1, 1);
      addVec("handlerMisaligned",  1, 1, 0, 0, 1, 32'h00400203, 32'h00400200, 32'h00400000, 1, 1);
      addVec("stallWithRequests",  1, 0, 1, 1, 1, 32'h00401000, 32'h00400200, 32'h00400000, 1, 1);
      addVec("resetInHandler",     0, 1, 0, 1, 0, 32'h0,        32'h00400000, 32'h0,        0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].exc, vecs[i].eret,
                       vecs[i].rv, vecs[i].target);
         checkOutput({vecs[i].name, ".pc"},    pc_out,             vecs[i].expPc);
         checkOutput({vecs[i].name, ".epc"},   epc_out,            vecs[i].expEpc);
         checkOutput({vecs[i].name, ".cause"}, {30'b0, exc_cause}, {30'b0, vecs[i].expCause});
         checkOutput({vecs[i].name, ".hdl"},   {31'b0, in_handler}, {31'b0, vecs[i].expHandler});
      end

      // Randomized run against the model
      for (int n = 0; n < 1500; n++) begin
         logic        r, e, x, er, rv;
         logic [31:0] t;
         r  = ($urandom_range(99) >= 2);
         e  = ($urandom_range(99) < 80);
         x  = ($urandom_range(99) < 10);
         er = ($urandom_range(99) < 15);
         rv = ($urandom_range(99) < 25);
         t  = $urandom;
         if ($urandom_range(1) == 0) t = t & ~32'h3;
         applyStimulus(r, e, x, er, rv, t);
         checkOutput("rand.pc",    pc_out,              mPc);
         checkOutput("rand.epc",   epc_out,             mEpc);
         checkOutput("rand.cause", {30'b0, exc_cause},  {30'b0, mCause});
         checkOutput("rand.hdl",   {31'b0, in_handler}, {31'b0, mHandler});
      end

      // 8-bit instance: wrap-around and reset while in the handler
      ena = 1'b0;
      step8(1'b0, 1'b0, 1'b0);
      checkOutput("w8.reset.pc",   {24'b0, pcOut8},  32'h000000FC);
      step8(1'b1, 1'b1, 1'b0);
      checkOutput("w8.wrap.pc",    {24'b0, pcOut8},  32'h00000000);
      step8(1'b1, 1'b1, 1'b1);
      checkOutput("w8.exc.pc",     {24'b0, pcOut8},  32'h00000080);
      checkOutput("w8.exc.epc",    {24'b0, epcOut8}, 32'h00000000);
      checkOutput("w8.exc.hdl",    {31'b0, inHandler8}, 32'h1);
      step8(1'b0, 1'b1, 1'b0);
      checkOutput("w8.rstHdl.pc",  {24'b0, pcOut8},  32'h000000FC);
      checkOutput("w8.rstHdl.hdl", {31'b0, inHandler8}, 32'h0);
      checkOutput("w8.rstHdl.cause", {30'b0, excCause8}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits, at least 8.
REQ-002 Parameter RESET_VEC, default 32'h00400000: PC value after reset.
REQ-003 Parameter EXC_VEC, default 32'h80000180: exception handler entry address.
REQ-004 Parameter INC, default 4: sequential PC increment.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-low.
REQ-007 ena  input  1  advance enable; 0 = stall (hold all state).
REQ-008 redir_valid  input  1  branch/jump redirect request.
REQ-009 redir_pc  input  WIDTH  redirect target.
REQ-010 exc_req  input  1  external exception request.
REQ-011 eret_req  input  1  return-from-exception request.
REQ-012 pc_out  output  WIDTH  current PC (registered).
REQ-013 epc_out  output  WIDTH  saved exception PC (registered).
REQ-014 exc_cause  output  2  last cause: 0 = none, 1 = external, 2 = misaligned target.
REQ-015 in_handler  output  1  high while FSM is in HANDLER.

Function
REQ-016 FSM SHALL have two states: RUN and HANDLER.
REQ-017 Requests SHALL be sampled only when ena=1; with ena=0 all registers hold, including under pending requests.
REQ-018 Priority when ena=1 SHALL be: exception > eret > redirect > increment.
REQ-019 Exception in RUN: pc_out<=EXC_VEC, epc_out<=pc_out, exc_cause<=1, next state HANDLER.
REQ-020 exc_req in HANDLER SHALL be ignored (no nesting); lower-priority requests are evaluated as if exc_req=0.
REQ-021 eret_req in HANDLER: pc_out<=epc_out, exc_cause<=0, next state RUN.
REQ-022 eret_req in RUN SHALL be ignored; lower-priority requests are evaluated as if eret_req=0.
REQ-023 Redirect SHALL give pc_out<=redir_pc in either state, with one-cycle latency.
REQ-024 With no request: pc_out<=pc_out+INC, modulo 2^WIDTH; wrap-around is silent.
REQ-025 epc_out SHALL change only on an accepted exception.

Reset
REQ-026 When rst=0 at a rising edge: pc_out=RESET_VEC, epc_out=0, exc_cause=0, state RUN; overrides ena and all requests.
REQ-027 Reset asserted while in HANDLER SHALL return the FSM to RUN with no eret required.

Configuration
REQ-028 Macro PC_ALIGN_TRAP_EN defined: a redirect in RUN with redir_pc[1:0]!=0 SHALL instead act as an exception: pc_out<=EXC_VEC, epc_out<=redir_pc, exc_cause<=2, state HANDLER.
REQ-029 A misaligned redirect in HANDLER SHALL force bits [1:0] to 0 (no trap).
REQ-030 Macro not defined: redir_pc[1:0] SHALL always be forced to 0; exc_cause never takes value 2.

Structure
REQ-031 Shared package holds the FSM state typedef (RUN, HANDLER), the exc_cause encodings and the default vector constants.
REQ-032 Sub-module pc_next (combinational next-PC/priority mux) is natural; FSM and registers live in pc_unit.
REQ-033 Expected size is 120-400 RTL lines.

Verification
REQ-034 Reset then 3 cycles with ena=1: pc_out = 00400000, 00400004, 00400008, 0040000C.
REQ-035 redir_pc=00401000 together with ena=0, then ena=1: pc_out holds, then is 00401000 on the next edge.
REQ-036 At pc=00400010, exc_req and redir_valid both high: pc_out=80000180, epc_out=00400010, exc_cause=1, in_handler=1; a second exc_req is ignored; eret_req returns pc_out to 00400010.
REQ-037 With PC_ALIGN_TRAP_EN, redir_pc=00400102: pc_out=80000180, epc_out=00400102, exc_cause=2; without the macro, pc_out=00400100.
REQ-038 WIDTH=8, RESET_VEC=8'hFC: pc_out goes FC then 00; reset asserted in HANDLER gives pc_out=FC and in_handler=0.
